bus_responder: RTL and testbench
================================

BUS_RESPONDER -- requirements
Module: bus_responder

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, number of wait-state cycles inserted before each access (legal range 0..15).
REQ-002 Parameter DEPTH, default 16, number of 32-bit storage words (fixed by the 4-bit address).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 bus_wr  input  1  single-cycle write request strobe from initiator.
REQ-006 bus_rd  input  1  single-cycle read request strobe from initiator.
REQ-007 bus_byte  input  4  byte enables; bit i selects wdata/rdata bits [8i+7:8i].
REQ-008 bus_addr  input  4  word address.
REQ-009 bus_wdata  input  32  write data.
REQ-010 bus_rdata_v  output  1  one-cycle read-data-valid pulse.
REQ-011 bus_rdata  output  32  read data; holds its value until the next read completes.
REQ-012 trans_over  output  1  high when idle and able to accept a request.

Function
REQ-013 States SHALL be IDLE, WAIT, ACCESS; trans_over SHALL equal (state == IDLE), combinationally.
REQ-014 In IDLE, a request sampled at the clock edge (bus_wr or bus_rd high) SHALL be accepted: addr, byte, wdata and the operation type are latched.
REQ-015 On acceptance: next state WAIT if WAIT_CYCLES > 0, else ACCESS.
REQ-016 WAIT SHALL last exactly WAIT_CYCLES cycles, counted by a 4-bit down-counter loaded with WAIT_CYCLES-1, then go to ACCESS.
REQ-017 ACCESS SHALL last exactly one cycle, then return to IDLE.
REQ-018 Timing: request high in cycle T -> trans_over low in cycles T+1 .. T+WAIT_CYCLES+1 and high again in cycle T+WAIT_CYCLES+2.
REQ-019 Write: at the edge ending ACCESS, only the bytes with bus_byte bit set SHALL be updated; new data is readable by any request accepted afterwards.
REQ-020 Read: at the edge ending ACCESS, bus_rdata SHALL load the stored word with non-enabled bytes forced to 0, and bus_rdata_v SHALL be high for exactly cycle T+WAIT_CYCLES+2.
REQ-021 bus_rdata_v SHALL never assert for writes.
REQ-022 bus_wr and bus_rd high together in IDLE: a write SHALL be performed and the read is discarded (no bus_rdata_v).
REQ-023 Requests arriving while not in IDLE SHALL be ignored, with no latching or queuing.
REQ-024 bus_byte = 4'b0000: full handshake timing, no storage change; a read returns 32'h0 with bus_rdata_v pulsed.
REQ-025 A request in the first IDLE cycle after ACCESS SHALL be accepted (back-to-back operation, no bubble beyond REQ-018).
REQ-026 Input strobes are level-sampled; a strobe held high for multiple IDLE cycles produces one transaction per acceptance (edge detection is the initiator's duty).

Reset
REQ-027 On rst_n low, immediately: state IDLE, trans_over 1, bus_rdata_v 0, bus_rdata 32'h0, wait counter 0, all storage words 32'h0, latched request cleared.
REQ-028 Reset asserted mid-transaction SHALL abort it: no write commit, no bus_rdata_v pulse.
REQ-029 After rst_n deasserts, the first rising edge SHALL be able to accept a request.

Structure
REQ-030 Shared package bus_pkg SHALL hold the state enumeration, ADDR_W=4, DATA_W=32 and BYTE_W=4 constants, and is shared with the initiator side.
REQ-031 Storage SHALL be a sub-module bus_regfile (DEPTH x 32, byte-enable write port, asynchronous read port, async reset to zero); the FSM, counter and output registers stay in bus_responder.

Verification (WAIT_CYCLES=2 unless stated)
REQ-032 After reset, read addr 4'h3, byte 4'hF -> trans_over low 3 cycles, bus_rdata_v pulse 4 cycles after the request, bus_rdata 32'h0.
REQ-033 Write addr 4'h5, wdata 32'hDEADBEEF, byte 4'hF; then write 32'h11223344 with byte 4'b0101; then read addr 4'h5, byte 4'hF -> 32'hDE22BE44.
REQ-034 Read addr 4'h5, byte 4'b1100 -> 32'hDE220000; bus_wr and bus_rd together, wdata 32'h0, byte 4'hF at addr 4'h5 -> write occurs, no bus_rdata_v pulse, subsequent read gives 32'h0.
REQ-035 Issue bus_wr to addr 4'h1 during WAIT of a prior transaction -> ignored, addr 4'h1 still 32'h0; drop rst_n during WAIT of a write to addr 4'h2 -> trans_over high at once, addr 4'h2 reads 32'h0.
REQ-036 WAIT_CYCLES=0: read request in cycle T -> trans_over low only in T+1, bus_rdata_v in T+2; back-to-back reads issued in each IDLE cycle complete every 2 cycles.

Source files
------------

// File: rtl/bus_pkg.sv
// Types and constants shared by the bus responder and the initiator side.
// byte_mask() expands a byte-enable vector into a full-width data mask.
package bus_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;
    localparam int BYTE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2
    } bus_state_e;

    function automatic logic [DATA_W-1:0] byte_mask(input logic [BYTE_W-1:0] be);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int i = 0; i < BYTE_W; i++) begin
            m[i*8 +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/bus_regfile.sv
// Word storage for the bus responder: byte-enable write port, combinational
// read port, every word cleared by the asynchronous reset.
module bus_regfile
    import bus_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [BYTE_W-1:0] wbyte,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] wmask_s;

    assign wmask_s = byte_mask(wbyte);
    assign rdata   = mem_r[raddr];

    // Storage array: cleared on reset, merged with enabled bytes on a write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_r[i] <= '0;
            end
        end else if (we) begin
            mem_r[waddr] <= (mem_r[waddr] & ~wmask_s) | (wdata & wmask_s);
        end else begin
            mem_r[waddr] <= mem_r[waddr];
        end
    end

endmodule

// File: rtl/bus_responder.sv
// Bus target with programmable wait states: IDLE -> WAIT -> ACCESS handshake
// in front of a small byte-addressable register file.
module bus_responder
    import bus_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned DEPTH       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bus_wr,
    input  logic              bus_rd,
    input  logic [BYTE_W-1:0] bus_byte,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [DATA_W-1:0] bus_wdata,
    output logic              bus_rdata_v,
    output logic [DATA_W-1:0] bus_rdata,
    output logic              trans_over
);

    // The counter is loaded with WAIT_CYCLES-1 so that WAIT spans exactly WAIT_CYCLES cycles
    localparam bit         HAS_WAIT  = (WAIT_CYCLES != 0);
    localparam logic [3:0] WAIT_LOAD = HAS_WAIT ? 4'(WAIT_CYCLES - 1) : 4'd0;

    bus_state_e        state_r;
    logic [3:0]        cnt_r;
    logic [ADDR_W-1:0] addr_r;
    logic [BYTE_W-1:0] byte_r;
    logic [DATA_W-1:0] wdata_r;
    logic              is_wr_r;
    logic              rdata_v_r;
    logic [DATA_W-1:0] rdata_r;
    logic [DATA_W-1:0] rd_word_s;
    logic              we_s;

    assign we_s        = (state_r == ST_ACCESS) && is_wr_r;
    assign trans_over  = (state_r == ST_IDLE);
    assign bus_rdata_v = rdata_v_r;
    assign bus_rdata   = rdata_r;

    bus_regfile #(
        .DEPTH (DEPTH)
    ) u_regfile (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we_s),
        .waddr (addr_r),
        .wbyte (byte_r),
        .wdata (wdata_r),
        .raddr (addr_r),
        .rdata (rd_word_s)
    );

    // Handshake FSM, wait counter, request latch and read-data registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 4'd0;
            addr_r    <= '0;
            byte_r    <= '0;
            wdata_r   <= '0;
            is_wr_r   <= 1'b0;
            rdata_v_r <= 1'b0;
            rdata_r   <= '0;
        end else begin
            rdata_v_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus_wr || bus_rd) begin
                        addr_r  <= bus_addr;
                        byte_r  <= bus_byte;
                        wdata_r <= bus_wdata;
                        // A simultaneous read strobe is dropped in favour of the write
                        is_wr_r <= bus_wr;
                        if (HAS_WAIT) begin
                            state_r <= ST_WAIT;
                            cnt_r   <= WAIT_LOAD;
                        end else begin
                            state_r <= ST_ACCESS;
                            cnt_r   <= 4'd0;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r == 4'd0) begin
                        state_r <= ST_ACCESS;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_ACCESS: begin
                    state_r <= ST_IDLE;
                    if (!is_wr_r) begin
                        rdata_r   <= rd_word_s & byte_mask(byte_r);
                        rdata_v_r <= 1'b1;
                    end else begin
                        rdata_r <= rdata_r;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_responder.sv
// Scoreboard bench for bus_responder: one instance with two wait states,
// one with none, sharing clock and reset.
module tb_bus_responder;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        bus_wr, bus_rd;
    logic [3:0]  bus_byte, bus_addr;
    logic [31:0] bus_wdata, bus_rdata;
    logic        bus_rdata_v, trans_over;
    logic        b0_wr, b0_rd;
    logic [3:0]  b0_byte, b0_addr;
    logic [31:0] b0_wdata, b0_rdata;
    logic        b0_rdata_v, b0_trans_over;

    int          n_checks;
    int          n_fail;
    int          cyc;
    exp_t        q2[$];
    exp_t        q0[$];
    exp_t        e2, e0;
    logic [31:0] model2[16];
    logic [31:0] model0[16];

    bus_responder #(.WAIT_CYCLES(2), .DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus_wr(bus_wr), .bus_rd(bus_rd),
        .bus_byte(bus_byte), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata_v(bus_rdata_v), .bus_rdata(bus_rdata), .trans_over(trans_over)
    );

    bus_responder #(.WAIT_CYCLES(0), .DEPTH(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus_wr(b0_wr), .bus_rd(b0_rd),
        .bus_byte(b0_byte), .bus_addr(b0_addr), .bus_wdata(b0_wdata),
        .bus_rdata_v(b0_rdata_v), .bus_rdata(b0_rdata), .trans_over(b0_trans_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 32'h%08h, want 32'h%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction on the two-wait-state instance; optionally pokes a write in WAIT
    task automatic op2(input logic wr, input logic rd, input logic [3:0] a,
                       input logic [3:0] be, input logic [31:0] wd, input logic intrude);
        logic [31:0] m;
        check("idle_before", 32'(trans_over), 32'd1);
        bus_wr = wr; bus_rd = rd; bus_addr = a; bus_byte = be; bus_wdata = wd;
        m = mask(be);
        if (wr) model2[a] = (model2[a] & ~m) | (wd & m);
        else if (rd) q2.push_back('{model2[a] & m, cyc + 4});
        tick();
        bus_wr = 1'b0; bus_rd = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            if (intrude && k == 1) begin
                bus_wr = 1'b1; bus_addr = 4'h1; bus_byte = 4'hF; bus_wdata = 32'hFFFF_FFFF;
            end else begin
                bus_wr = 1'b0;
            end
            check("busy", 32'(trans_over), 32'd0);
            tick();
        end
        bus_wr = 1'b0;
        check("idle_after", 32'(trans_over), 32'd1);
    endtask

    // One transaction on the zero-wait-state instance
    task automatic op0(input logic wr, input logic [3:0] a, input logic [3:0] be,
                       input logic [31:0] wd);
        logic [31:0] m;
        check("idle0_before", 32'(b0_trans_over), 32'd1);
        b0_wr = wr; b0_rd = !wr; b0_addr = a; b0_byte = be; b0_wdata = wd;
        m = mask(be);
        if (wr) model0[a] = (model0[a] & ~m) | (wd & m);
        else q0.push_back('{model0[a] & m, cyc + 2});
        tick();
        b0_wr = 1'b0; b0_rd = 1'b0;
        check("busy0", 32'(b0_trans_over), 32'd0);
        tick();
        check("idle0_after", 32'(b0_trans_over), 32'd1);
    endtask

    // Scoreboard for the two-wait-state instance
    always @(negedge clk) begin
        if (bus_rdata_v) begin
            if (q2.size() == 0) begin
                check("rdv2_spurious", 32'(bus_rdata_v), 32'd0);
            end else begin
                e2 = q2.pop_front();
                check("rdata2", bus_rdata, e2.data);
                check("rdv2_cycle", 32'(cyc), 32'(e2.due));
            end
        end
    end

    // Scoreboard for the zero-wait-state instance
    always @(negedge clk) begin
        if (b0_rdata_v) begin
            if (q0.size() == 0) begin
                check("rdv0_spurious", 32'(b0_rdata_v), 32'd0);
            end else begin
                e0 = q0.pop_front();
                check("rdata0", b0_rdata, e0.data);
                check("rdv0_cycle", 32'(cyc), 32'(e0.due));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0; n_fail = 0; cyc = 0;
        for (int i = 0; i < 16; i++) begin
            model2[i] = 32'h0;
            model0[i] = 32'h0;
        end
        rst_n = 1'b0;
        bus_wr = 1'b0; bus_rd = 1'b0; bus_byte = 4'h0; bus_addr = 4'h0; bus_wdata = 32'h0;
        b0_wr = 1'b0; b0_rd = 1'b0; b0_byte = 4'h0; b0_addr = 4'h0; b0_wdata = 32'h0;
        #1;
        check("rst_trans_over", 32'(trans_over), 32'd1);
        check("rst_rdata_v", 32'(bus_rdata_v), 32'd0);
        check("rst_rdata", bus_rdata, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;

        op2(1'b0, 1'b1, 4'h3, 4'hF, 32'h0, 1'b0);
        op2(1'b1, 1'b0, 4'h5, 4'hF, 32'hDEAD_BEEF, 1'b0);
        op2(1'b1, 1'b0, 4'h5, 4'b0101, 32'h1122_3344, 1'b0);
        op2(1'b0, 1'b1, 4'h5, 4'hF, 32'h0, 1'b0);
        op2(1'b0, 1'b1, 4'h5, 4'b1100, 32'h0, 1'b0);
        op2(1'b0, 1'b1, 4'h5, 4'b0000, 32'h0, 1'b0);
        op2(1'b1, 1'b0, 4'h5, 4'b0000, 32'hFFFF_FFFF, 1'b0);
        op2(1'b0, 1'b1, 4'h5, 4'hF, 32'h0, 1'b0);
        op2(1'b0, 1'b1, 4'h0, 4'hF, 32'h0, 1'b1);
        op2(1'b0, 1'b1, 4'h1, 4'hF, 32'h0, 1'b0);
        op2(1'b0, 1'b1, 4'h5, 4'hF, 32'h0, 1'b0);

        // Reset during WAIT of a write: nothing commits, outputs clear at once
        bus_wr = 1'b1; bus_addr = 4'h2; bus_byte = 4'hF; bus_wdata = 32'hCAFE_F00D;
        tick();
        bus_wr = 1'b0;
        check("busy_pre_rst", 32'(trans_over), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_trans_over", 32'(trans_over), 32'd1);
        check("midrst_rdata", bus_rdata, 32'h0);
        check("midrst_rdata_v", 32'(bus_rdata_v), 32'd0);
        for (int i = 0; i < 16; i++) model2[i] = 32'h0;
        q2.delete();
        tick();
        tick();
        rst_n = 1'b1;
        op2(1'b0, 1'b1, 4'h2, 4'hF, 32'h0, 1'b0);
        op2(1'b0, 1'b1, 4'h5, 4'hF, 32'h0, 1'b0);

        // Write and read strobes together: write wins, no read pulse
        op2(1'b1, 1'b0, 4'h5, 4'hF, 32'hDEAD_BEEF, 1'b0);
        op2(1'b1, 1'b1, 4'h5, 4'hF, 32'h0, 1'b0);
        op2(1'b0, 1'b1, 4'h5, 4'hF, 32'h0, 1'b0);

        // Zero-wait-state instance
        op0(1'b1, 4'h7, 4'hF, 32'hA5A5_0F0F);
        op0(1'b1, 4'h8, 4'b0011, 32'h1234_5678);
        op0(1'b0, 4'h7, 4'hF, 32'h0);

        // Read strobe held high: accepted every other cycle, busy-cycle address ignored
        for (int k = 0; k < 8; k++) begin
            b0_rd = 1'b1;
            b0_byte = 4'hF;
            if (k % 2 == 0) begin
                b0_addr = (k % 4 == 0) ? 4'h7 : 4'h8;
                q0.push_back('{model0[b0_addr], cyc + 2});
                check("idle0_b2b", 32'(b0_trans_over), 32'd1);
            end else begin
                b0_addr = 4'hC;
                check("busy0_b2b", 32'(b0_trans_over), 32'd0);
            end
            tick();
        end
        b0_rd = 1'b0;
        tick();
        tick();
        tick();

        check("q2_drained", 32'(q2.size()), 32'd0);
        check("q0_drained", 32'(q0.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
